bf_sbox_writer: RTL
===================

Name: bf_sbox_writer

Overview:
- Writable 256 x 32 Blowfish S-box store. The write side fills it during key expansion; the read side serves F-function lookups (8-bit index to 32-bit word).
- The write side accepts a valid/ready word stream and writes addresses 0..255 in order. The read side is a registered single-cycle lookup port.
- Replaces constant S-box tables once key-dependent S-box regeneration is required.

Parameters:
- ADDR_W, 8, index width; depth = 2**ADDR_W entries.
- DATA_W, 32, S-box word width.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- start  in  1  pulse; begin (or restart) a full load from address 0.
- wr_valid  in  1  write word valid.
- wr_data  in  DATA_W  word for the current write address.
- wr_ready  out  1  writer accepts a word this cycle.
- busy  out  1  load in progress.
- done  out  1  level; all 2**ADDR_W entries written since the last start.
- words_loaded  out  ADDR_W+1  count of words accepted in the current load.
- rd_en  in  1  lookup request.
- rd_addr  in  ADDR_W  lookup index.
- rd_data  out  DATA_W  lookup result, registered.
- rd_valid  out  1  pulse; rd_data valid this cycle.
- par_err  out  1  sticky parity error flag; tied 0 when the feature is compiled out.

Behaviour:
- Reset values: state IDLE, write pointer 0, wr_ready 0, busy 0, done 0, words_loaded 0, rd_data 0, rd_valid 0, par_err 0. Memory contents are not reset and are undefined until written.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - start moves to LOAD and clears pointer, words_loaded and done.
  - wr_ready is 0; wr_valid is ignored.
- LOAD:
  - busy = 1 and wr_ready = 1 (combinational from state).
  - Handshake is wr_valid & wr_ready. On a handshake, mem[ptr] <= wr_data, ptr++ and words_loaded++.
  - The handshake at ptr == 2**ADDR_W-1 moves to DONE next cycle with done = 1, words_loaded = 256 and ptr wrapped to 0.
- DONE:
  - busy 0, wr_ready 0; done holds until start.
  - start re-enters LOAD exactly as from IDLE.
- Start during LOAD (restart):
  - Pointer and words_loaded reset to 0; state stays LOAD.
  - Start has priority over a handshake in the same cycle: that word is dropped, not written.
  - Entries already written keep their values until overwritten.
- Reads:
  - Permitted in any state. rd_en at cycle N gives rd_data = mem[rd_addr] and rd_valid = 1 at cycle N+1.
  - Without rd_en, rd_valid = 0 and rd_data holds its last value.
- Simultaneous read and write to the same address: read-before-write; rd_data returns the old contents.
- Back-to-back: one write and one read are accepted every cycle; no bubbles.
- Reset mid-load: FSM returns to IDLE immediately (async); memory contents are retained but not guaranteed.

Optional Feature:
- Macro: BF_SBOX_PARITY_EN.
- Enabled:
  - Each entry stores an extra bit = ^wr_data.
  - On each read, recomputed parity is compared with the stored bit in the registered read stage.
  - A mismatch sets par_err (sticky), visible in the same cycle as rd_valid.
  - par_err clears on start or reset. Reads of never-written entries are excluded from the check.
  - A per-entry written bitmap is kept; it is cleared on reset only.
- Disabled: no parity storage and no bitmap; par_err is constant 0.

Decomposition:
- Shared package bf_pkg: BF_SBOX_ADDR_W = 8, BF_SBOX_DATA_W = 32, BF_SBOX_DEPTH = 256, and the FSM state enum (IDLE, LOAD, DONE), reused by the other S-box and P-array writers.
- One sub-module: bf_sbox_mem, the 256-entry array with one synchronous write port and one registered read port (plus parity bit under the macro).
- The FSM, pointer and handshake stay in bf_sbox_writer.

Test Plan:
- Full load and readback:
  - Stimulus: reset, start, stream wr_data = {4{i[7:0]}} for i = 0..255 with wr_valid held high.
  - Response: done rises the cycle after the 256th handshake and words_loaded = 256.
  - Reading addr 0xA5 returns 0xA5A5A5A5 one cycle after rd_en.
- Backpressure:
  - Stimulus: toggle wr_valid randomly (about 50%) during a load.
  - Response: exactly 256 writes; every address i reads {4{i}}; wr_ready = 0 in IDLE and DONE.
- Restart:
  - Stimulus: start, write 10 words 0x11111111, start again while wr_valid is high, then load 256 words 0xDEADBEEF.
  - Response: the word in the start cycle is dropped; after done, addr 0x05 reads 0xDEADBEEF.
- Read/write collision:
  - Stimulus: reload with entry 0x03 previously 0x03030303; in the cycle the new word 0xCAFEF00D is written to addr 0x03, assert rd_en to addr 0x03.
  - Response: rd_data = 0x03030303; the next read returns 0xCAFEF00D.
- Async reset mid-load:
  - Stimulus: assert wb_rst_i after 100 words, between clock edges.
  - Response: busy, wr_ready, done and words_loaded drop to 0 immediately; state is IDLE after release.
- Parity (BF_SBOX_PARITY_EN only):
  - Stimulus: force-flip bit 0 of stored entry 0x10, then read it.
  - Response: par_err = 1 together with rd_valid and stays 1 until start.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared Blowfish key-schedule package: S-box geometry and the writer FSM state
// encoding reused by the S-box and P-array writers.
package bf_pkg;

    localparam int BF_SBOX_ADDR_W = 8;
    localparam int BF_SBOX_DATA_W = 32;
    localparam int BF_SBOX_DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } bf_state_e;

endpackage

// File: rtl/bf_sbox_writer_if.sv
// Load stream, status and lookup port of the S-box writer; slave is the
// design side, master the producer/consumer side.
interface bf_sbox_writer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_loaded;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              par_err;

    modport slave (
        input  start, wr_valid, wr_data, rd_en, rd_addr,
        output wr_ready, busy, done, words_loaded, rd_data, rd_valid, par_err
    );

    modport master (
        output start, wr_valid, wr_data, rd_en, rd_addr,
        input  wr_ready, busy, done, words_loaded, rd_data, rd_valid, par_err
    );
endinterface

// File: rtl/bf_sbox_mem.sv
// 2**ADDR_W x DATA_W S-box array: one synchronous write port, one registered
// read port (read-before-write). BF_SBOX_PARITY_EN adds per-entry parity.
module bf_sbox_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              par_clr,
    output logic              par_err
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= mem[rd_addr];
        end
    end

`ifdef BF_SBOX_PARITY_EN
    logic             par_mem [DEPTH];
    logic [DEPTH-1:0] written;

    always_ff @(posedge clk) begin
        if (wr_en) par_mem[wr_addr] <= ^wr_data;
    end

    // Never-written entries hold garbage parity, so the bitmap gates the check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written <= '0;
            par_err <= 1'b0;
        end else begin
            if (wr_en) written[wr_addr] <= 1'b1;
            if (par_clr)
                par_err <= 1'b0;
            else if (rd_en && written[rd_addr] && ((^mem[rd_addr]) != par_mem[rd_addr]))
                par_err <= 1'b1;
        end
    end
`else
    logic unused_par_clr;
    assign unused_par_clr = par_clr;
    assign par_err        = 1'b0;
`endif

endmodule

// File: rtl/bf_sbox_writer.sv
// Key-expansion S-box writer: fills addresses 0..2**ADDR_W-1 in order from a
// valid/ready stream and serves registered lookups. Option: BF_SBOX_PARITY_EN.
module bf_sbox_writer
    import bf_pkg::*;
#(
    parameter int ADDR_W = BF_SBOX_ADDR_W,
    parameter int DATA_W = BF_SBOX_DATA_W
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    bf_sbox_writer_if.slave  bus
);
    bf_state_e         state;
    logic [ADDR_W-1:0] ptr;
    logic              wr_en;

    // Start wins over a same-cycle handshake: that word is dropped.
    assign wr_en = (state == LOAD) && bus.wr_valid && !bus.start;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state            <= IDLE;
            ptr              <= '0;
            bus.wr_ready     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.words_loaded <= '0;
        end else if (bus.start) begin
            state            <= LOAD;
            ptr              <= '0;
            bus.wr_ready     <= 1'b1;
            bus.busy         <= 1'b1;
            bus.done         <= 1'b0;
            bus.words_loaded <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (wr_en) begin
                        ptr              <= ptr + 1'b1;
                        bus.words_loaded <= bus.words_loaded + 1'b1;
                        if (ptr == '1) begin
                            state        <= DONE;
                            bus.wr_ready <= 1'b0;
                            bus.busy     <= 1'b0;
                            bus.done     <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    bf_sbox_mem #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .wr_en    (wr_en),
        .wr_addr  (ptr),
        .wr_data  (bus.wr_data),
        .rd_en    (bus.rd_en),
        .rd_addr  (bus.rd_addr),
        .rd_data  (bus.rd_data),
        .rd_valid (bus.rd_valid),
        .par_clr  (bus.start),
        .par_err  (bus.par_err)
    );

endmodule
